operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/operand_entry.sv
// operand_entry
//   Captures two 6-bit two's-complement operands and an add/subtract select
//   from slide switches. A single active-low push-button drives the capture.
//   A short press steps LOAD_A -> LOAD_B -> SHOW -> LOAD_A. A long press
//   clears everything and returns to LOAD_A.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   button      raw push-button, 0 = pressed, asynchronous to clk
//   switches    operand value to capture
//   add_sub_sw  operation select to capture (0 = add, 1 = subtract)
//   A, B        captured operands
//   Add_Sub     captured operation select
//   valid       one-cycle pulse in the first SHOW cycle after B is captured
//   load_A_LED / load_B_LED / ready_LED   one-hot state indication
//   state       current FSM state (LOAD_A=0, LOAD_B=1, SHOW=2) for observation
//
// Handshake: valid is a pulse with no ready. A consumer samples A, B and
// Add_Sub in the cycle valid is high. Those values then hold until the next
// capture or clear.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic [5:0] switches,
  input  logic       add_sub_sw,
  output logic [5:0] A,
  output logic [5:0] B,
  output logic       Add_Sub,
  output logic       valid,
  output logic       load_A_LED,
  output logic       load_B_LED,
  output logic       ready_LED,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SHOW   = 2'd2
  } state_t;

  logic          sync_q1, sync_q2;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          long_seen;
  logic          db_accept, long_press, short_press;
  state_t        cur_state, nxt_state;
  logic          cap_a, cap_b, clr;

  // Two-flop synchronizer. It resets to the released level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  // The debounced level follows the synchronized level only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts
  // the count.
  assign db_accept = (sync_q2 != db_level) && (db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else if (sync_q2 != db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level <= sync_q2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // The hold counter saturates at LONG_CYCLES. The long press fires on the
  // single cycle where the count steps onto LONG_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (!db_level) begin
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  assign long_press = !db_level && (hold_cnt == HOLD_LAST);

  // long_seen stays set for the rest of the hold. It suppresses the short
  // press on release. It clears once the debounced level reads released again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           long_seen <= 1'b0;
    else if (long_press) long_seen <= 1'b1;
    else if (db_level)   long_seen <= 1'b0;
  end

  // A release is accepted when the debounced level is about to go 0 -> 1.
  assign short_press = db_accept && !db_level && !long_seen && !long_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= LOAD_A;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    clr       = 1'b0;
    if (long_press) begin
      clr       = 1'b1;
      nxt_state = LOAD_A;
    end else if (short_press) begin
      case (cur_state)
        LOAD_A: begin
          cap_a     = 1'b1;
          nxt_state = LOAD_B;
        end
        LOAD_B: begin
          cap_b     = 1'b1;
          nxt_state = SHOW;
        end
        SHOW:    nxt_state = LOAD_A;
        default: nxt_state = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A       <= '0;
      B       <= '0;
      Add_Sub <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= cap_b;
      if (clr) begin
        A       <= '0;
        B       <= '0;
        Add_Sub <= 1'b0;
      end else begin
        if (cap_a) A <= switches;
        if (cap_b) begin
          B       <= switches;
          Add_Sub <= add_sub_sw;
        end
      end
    end
  end

  assign load_A_LED = (cur_state == LOAD_A);
  assign load_B_LED = (cur_state == LOAD_B);
  assign ready_LED  = (cur_state == SHOW);
  assign state      = cur_state;

endmodule
